// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ifu_state_t;

  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int ALU_MSB = 26;
  localparam int ALU_LSB = 24;

endpackage

// File: rtl/ifu_fifo.sv
// In-order prefetch FIFO. The head is read straight out of the storage
// registers, so a word pushed at one edge is visible right after that edge.
// Push and pop may coincide at any occupancy; flush wins over both.
module ifu_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointer / occupancy update and storage write.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      do_pop  = pop && (count_q != '0);
      do_push = push && ((count_q != FULL_CNT) || do_pop);
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, credit-limited memory
// requests, in-order prefetch buffering and redirect flush.
// Optional build macro IFU_PERF_CNT_EN adds perf_fetched / perf_flushed.
//
// state | meaning
// BOOT  | first cycle after reset release, no fetch
// RUN   | issuing fetches and buffering responses
// FLUSH | dropping responses that belong to a redirected-away path
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [4:0]         OPcode,
  output logic [2:0]         ALUop
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int FW    = INSTR_W + ADDR_W;

  ifu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  discard_q, discard_d;

  logic [CNT_W-1:0]  fifo_count;
  logic [FW-1:0]     fifo_head;
  logic              fifo_valid;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;

  logic              credit_ok;
  logic              grant;
  logic              rsp_drop;
  logic [CNT_W-1:0]  stale_total;
  logic [ADDR_W-1:0] redirect_aligned;

  // Credits cover both buffered words and requests still in flight.
  assign credit_ok = ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(outstanding_q))
                     < (CNT_W+1)'(DEPTH);

  // Only one of outstanding/discard is ever non-zero, so the sum fits.
  assign stale_total      = outstanding_q + discard_q;
  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

  // Next-state, request and bookkeeping; redirect overrides everything.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    imem_req      = 1'b0;
    grant         = 1'b0;
    fifo_push     = 1'b0;
    fifo_flush    = 1'b0;
    rsp_drop      = 1'b0;
    if (redirect_valid) begin
      fifo_flush    = 1'b1;
      rsp_drop      = imem_rvalid && (stale_total != '0);
      fetch_pc_d    = redirect_aligned;
      resp_pc_d     = redirect_aligned;
      outstanding_d = '0;
      discard_d     = stale_total - CNT_W'(rsp_drop);
      state_d       = (discard_d != '0) ? FLUSH : RUN;
    end else begin
      case (state_q)
        BOOT: begin
          state_d = RUN;
        end
        RUN: begin
          imem_req = credit_ok;
          grant    = imem_req && imem_gnt;
          if (imem_rvalid && (outstanding_q != '0)) begin
            fifo_push = 1'b1;
            resp_pc_d = resp_pc_q + ADDR_W'(4);
          end
          if (grant) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
          end
          outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(fifo_push);
        end
        FLUSH: begin
          rsp_drop  = imem_rvalid && (discard_q != '0);
          discard_d = discard_q - CNT_W'(rsp_drop);
          if (discard_d == '0) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign fifo_pop = instr_valid && instr_ready;

  ifu_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_data  ({imem_rdata, resp_pc_q}),
    .pop        (fifo_pop),
    .flush      (fifo_flush),
    .head_data  (fifo_head),
    .head_valid (fifo_valid),
    .count      (fifo_count)
  );

  assign imem_addr   = fetch_pc_q;
  assign instr_valid = fifo_valid;
  assign instr       = fifo_head[ADDR_W +: INSTR_W];
  assign instr_pc    = fifo_head[ADDR_W-1:0];
  assign OPcode      = instr[OPC_MSB:OPC_LSB];
  assign ALUop       = instr[ALU_MSB:ALU_LSB];

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;

  // Pops, plus every buffered word or stale response thrown away.
  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(fifo_pop);
    perf_flushed_d = perf_flushed_q + 32'(rsp_drop);
    if (redirect_valid) begin
      perf_flushed_d = perf_flushed_d + 32'(fifo_count);
    end
  end

  // Wrapping performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule
